configs_loader: RTL and testbench

CONFIGS_LOADER -- requirements
Module: configs_loader

---
 rtl/configs_pkg.sv | 17 +
 rtl/configs_bank.sv | 36 +++
 rtl/configs_loader.sv | 127 ++++++++++++
 tb/tb_configs_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/configs_pkg.sv
// Shared definitions for the configuration loader: FSM states and the
// readback address width helper.
// Contents: state_t (IDLE/LOAD/CHECK), calc_aw(n) = max(1, clog2(n)).
package configs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Index width for n words; never zero so a 1-word build still has a port.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/configs_bank.sv
// NUM_WORDS x WORD_W register bank with a single-word write port and a
// whole-bank load port; contents are presented flat on q.
// Latency: writes/loads visible one edge later. No backpressure.
// Ports: clk, reset (sync, active-low), we/waddr/wdata (word write),
//        ld/ld_data (whole-bank load, wins over we), q (flat contents).
module configs_bank
  import configs_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 10,
  parameter int AW        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [WORD_W-1:0]           wdata,
  input  logic                        ld,
  input  logic [WORD_W*NUM_WORDS-1:0] ld_data,
  output logic [WORD_W*NUM_WORDS-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_data;
    end else if (we) begin
      // Per-word compare keeps out-of-range indices from touching anything.
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (waddr == AW'(i)) q[i*WORD_W +: WORD_W] <= wdata;
      end
    end
  end

endmodule

// File: rtl/configs_loader.sv
// Streams NUM_WORDS config words into a shadow bank, verifies an XOR
// checksum word, then commits shadow to the active bank in one edge.
// Latency: commit and io_done one edge after the checksum transfer.
// Backpressure: io_d_ready high in LOAD/CHECK, independent of io_d_valid.
// Ports: clk, reset (sync, active-low), io_start, io_abort,
//        io_d_in/io_d_valid/io_d_ready (stream), io_configs_out (active),
//        io_rd_addr/io_rd_data (readback), io_busy, io_done, io_err.
module configs_loader
  import configs_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              io_start,
  input  logic                              io_abort,
  input  logic [WORD_W-1:0]                 io_d_in,
  input  logic                              io_d_valid,
  output logic                              io_d_ready,
  output logic [WORD_W*NUM_WORDS-1:0]       io_configs_out,
  input  logic [calc_aw(NUM_WORDS)-1:0]     io_rd_addr,
  output logic [WORD_W-1:0]                 io_rd_data,
  output logic                              io_busy,
  output logic                              io_done,
  output logic                              io_err
);

  localparam int AW = calc_aw(NUM_WORDS);
  localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);

  state_t                      state;
  logic [AW-1:0]               addr;
  logic [WORD_W-1:0]           chk;
  logic                        done;
  logic                        err;
  logic                        xfer;
  logic                        accept_data;
  logic                        shadow_we;
  logic                        commit;
  logic [WORD_W*NUM_WORDS-1:0] shadow_q;
  logic [WORD_W*NUM_WORDS-1:0] active_q;

  assign io_d_ready = (state != IDLE);
  assign xfer       = io_d_valid && io_d_ready;
  // start/abort swallow any word presented in the same cycle.
  assign accept_data = xfer && !io_start && !io_abort;
  assign shadow_we   = accept_data && (state == LOAD);
  assign commit      = accept_data && (state == CHECK) && (io_d_in == chk);

  configs_bank #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .AW        (AW)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .we      (shadow_we),
    .waddr   (addr),
    .wdata   (io_d_in),
    .ld      (1'b0),
    .ld_data ('0),
    .q       (shadow_q)
  );

  configs_bank #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .AW        (AW)
  ) u_active (
    .clk     (clk),
    .reset   (reset),
    .we      (1'b0),
    .waddr   ('0),
    .wdata   ('0),
    .ld      (commit),
    .ld_data (shadow_q),
    .q       (active_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      addr  <= '0;
      chk   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= commit;
      if (io_abort) begin
        state <= IDLE;
      end else if (io_start) begin
        state <= LOAD;
        addr  <= '0;
        chk   <= '0;
        err   <= 1'b0;
      end else if (xfer) begin
        case (state)
          LOAD: begin
            chk  <= chk ^ io_d_in;
            addr <= addr + 1'b1;
            if (addr == LAST) state <= CHECK;
          end
          CHECK: begin
            if (io_d_in != chk) err <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Out-of-range readback indices fall through to zero.
  always_comb begin
    io_rd_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (io_rd_addr == AW'(i)) io_rd_data = active_q[i*WORD_W +: WORD_W];
    end
  end

  assign io_configs_out = active_q;
  assign io_busy        = (state != IDLE);
  assign io_done        = done;
  assign io_err         = err;

endmodule

// File: tb/tb_configs_loader.sv
// Scoreboard bench for configs_loader (10-word and 1-word builds).
// Stimulus pushes expected commit/error events; monitors pop on io_done
// pulses and io_err rising edges and compare the active configuration.
module tb_configs_loader;

  typedef struct {
    logic         is_err;
    logic [319:0] cfg;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         io_start, io_abort, io_d_valid;
  logic [31:0]  io_d_in;
  logic         io_d_ready, io_busy, io_done, io_err;
  logic [319:0] io_configs_out;
  logic [3:0]   io_rd_addr;
  logic [31:0]  io_rd_data;

  logic         s1_start, s1_abort, s1_d_valid;
  logic [31:0]  s1_d_in;
  logic         s1_d_ready, s1_busy, s1_done, s1_err;
  logic [31:0]  s1_cfg;
  logic [0:0]   s1_rd_addr;
  logic [31:0]  s1_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  ev_t          sb_q[$];
  logic [31:0]  sb1_q[$];

  always #5 clk = ~clk;

  configs_loader #(.WORD_W(32), .NUM_WORDS(10)) u_dut (
    .clk(clk), .reset(reset), .io_start(io_start), .io_abort(io_abort),
    .io_d_in(io_d_in), .io_d_valid(io_d_valid), .io_d_ready(io_d_ready),
    .io_configs_out(io_configs_out), .io_rd_addr(io_rd_addr),
    .io_rd_data(io_rd_data), .io_busy(io_busy), .io_done(io_done),
    .io_err(io_err)
  );

  configs_loader #(.WORD_W(32), .NUM_WORDS(1)) u_dut1 (
    .clk(clk), .reset(reset), .io_start(s1_start), .io_abort(s1_abort),
    .io_d_in(s1_d_in), .io_d_valid(s1_d_valid), .io_d_ready(s1_d_ready),
    .io_configs_out(s1_cfg), .io_rd_addr(s1_rd_addr),
    .io_rd_data(s1_rd_data), .io_busy(s1_busy), .io_done(s1_done),
    .io_err(s1_err)
  );

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [319:0] cfg_seq(input logic [31:0] base);
    logic [319:0] c;
    c = '0;
    for (int i = 0; i < 10; i++) c[i*32 +: 32] = base + 32'(i);
    return c;
  endfunction

  task automatic do_start();
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
  endtask

  // Idle gap cycles carry junk data that must never be written.
  task automatic put(input logic [31:0] w, input int gap);
    for (int k = 0; k < gap; k++) begin
      io_d_valid = 1'b0;
      io_d_in    = 32'hDEAD_0000 | 32'(k);
      tick();
    end
    io_d_valid = 1'b1;
    io_d_in    = w;
    tick();
    io_d_valid = 1'b0;
  endtask

  task automatic put_seq(input logic [31:0] base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) put(base + 32'(i), gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  // Monitor for the 10-word build.
  initial begin : mon
    logic err_prev;
    ev_t  e;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (io_done === 1'b1 || (io_err === 1'b1 && err_prev !== 1'b1)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", {io_done, io_err}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          check("event_kind_err", io_err === 1'b1 && io_done !== 1'b1, e.is_err);
          check("event_configs", io_configs_out, e.cfg);
        end
      end
      err_prev = io_err;
    end
  end

  // Monitor for the 1-word build.
  initial begin : mon1
    forever begin
      @(negedge clk);
      if (s1_done === 1'b1) begin
        if (sb1_q.size() == 0) check("n1_unexpected_done", 1, 0);
        else check("n1_configs", s1_cfg, sb1_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; io_start = 0; io_abort = 0; io_d_valid = 0; io_d_in = '0; io_rd_addr = '0;
    s1_start = 0; s1_abort = 0; s1_d_valid = 0; s1_d_in = '0; s1_rd_addr = '0;
    tick(); tick();
    check("rst_configs", io_configs_out, '0);
    check("rst_rd_data", io_rd_data, '0);
    check("rst_ready_busy_done_err", {io_d_ready, io_busy, io_done, io_err}, 4'b0000);
    check("rst_n1_cfg", s1_cfg, '0);
    reset = 1'b1;
    tick();

    // Nominal session.
    do_start();
    check("busy_in_load", {io_busy, io_d_ready}, 2'b11);
    put_seq(32'h1, 10, 1'b0);
    check("busy_in_check", io_busy, 1'b1);
    sb_q.push_back('{is_err: 1'b0, cfg: cfg_seq(32'h1)});
    put(32'h0000_000B, 0);
    check("done_high", io_done, 1'b1);
    check("cfg_word0", io_configs_out[31:0], 32'h1);
    check("cfg_word9", io_configs_out[319:288], 32'hA);
    io_rd_addr = 4'd3;
    #1 check("rd_addr3", io_rd_data, 32'h4);
    io_rd_addr = 4'd12;
    #1 check("rd_addr_oob", io_rd_data, 32'h0);
    tick();
    check("done_one_cycle", {io_done, io_busy}, 2'b00);

    // Bad checksum: different words so "unchanged" is observable.
    do_start();
    put_seq(32'h21, 10, 1'b0);
    sb_q.push_back('{is_err: 1'b1, cfg: cfg_seq(32'h1)});
    put(32'h0, 0);
    check("bad_err_set", {io_err, io_busy, io_done}, 3'b100);
    tick(); tick();
    check("bad_err_sticky", io_err, 1'b1);
    io_start = 1'b1; io_abort = 1'b1;
    tick();
    io_start = 1'b0; io_abort = 1'b0;
    check("err_kept_start_abort", {io_err, io_busy}, 2'b10);
    do_start();
    check("err_cleared_by_start", io_err, 1'b0);
    io_abort = 1'b1; tick(); io_abort = 1'b0;

    // Abort after 5 words, then a full new session.
    do_start();
    put_seq(32'h30, 5, 1'b0);
    io_abort = 1'b1; tick(); io_abort = 1'b0;
    check("abort_idle", {io_busy, io_done, io_err}, 3'b000);
    check("abort_active_kept", io_configs_out, cfg_seq(32'h1));
    do_start();
    put_seq(32'h10, 10, 1'b0);
    sb_q.push_back('{is_err: 1'b0, cfg: cfg_seq(32'h10)});
    put(32'h0000_0001, 0);
    tick();

    // Start+abort collision mid-LOAD, then restart mid-LOAD with a live word.
    do_start();
    put_seq(32'h70, 2, 1'b0);
    io_start = 1'b1; io_abort = 1'b1;
    tick();
    io_start = 1'b0; io_abort = 1'b0;
    check("collision_idle", {io_busy, io_d_ready}, 2'b00);
    do_start();
    put_seq(32'h40, 3, 1'b0);
    io_start = 1'b1; io_d_valid = 1'b1; io_d_in = 32'h0000_0BAD;
    tick();
    io_start = 1'b0; io_d_valid = 1'b0;
    put_seq(32'h50, 10, 1'b0);
    sb_q.push_back('{is_err: 1'b0, cfg: cfg_seq(32'h50)});
    put(32'h0000_0001, 0);
    tick();

    // Backpressure / gaps: same result as the nominal session.
    do_start();
    put_seq(32'h1, 10, 1'b1);
    sb_q.push_back('{is_err: 1'b0, cfg: cfg_seq(32'h1)});
    put(32'h0000_000B, 2);
    tick();
    check("gaps_result", io_configs_out, cfg_seq(32'h1));

    // Reset while in CHECK with a correct checksum presented.
    do_start();
    put_seq(32'h60, 10, 1'b0);
    reset = 1'b0; io_d_valid = 1'b1; io_d_in = 32'h0000_0001;
    tick();
    io_d_valid = 1'b0; reset = 1'b1;
    io_rd_addr = 4'd0;
    #1;
    check("rst_check_configs", io_configs_out, '0);
    check("rst_check_rd_data", io_rd_data, '0);
    check("rst_check_flags", {io_d_ready, io_busy, io_done, io_err}, 4'b0000);
    tick();
    check("rst_check_no_done", io_done, 1'b0);

    // One-word build: first transfer is data, second is the checksum.
    s1_start = 1'b1; tick(); s1_start = 1'b0;
    s1_d_valid = 1'b1; s1_d_in = 32'h5A; tick();
    check("n1_in_check", {s1_busy, s1_d_ready}, 2'b11);
    sb1_q.push_back(32'h5A);
    tick();
    s1_d_valid = 1'b0;
    check("n1_done", {s1_done, s1_err, s1_busy}, 3'b100);
    check("n1_rd_data", s1_rd_data, 32'h5A);
    tick(); tick();

    check("sb_drained", 320'(sb_q.size()), 320'd0);
    check("sb1_drained", 320'(sb1_q.size()), 320'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
